// File: rtl/csoc_uart_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : csoc_uart_seq_if
// Brief    : UART-side and CSoC-side signal bundle of the command sequencer.
// Revision : 1.0
// ============================================================================
interface csoc_uart_seq_if;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic       csoc_clk;
    logic       csoc_rstn;
    logic       csoc_test_se;
    logic       csoc_test_tm;
    logic [7:0] csoc_data_o;
    logic       csoc_uart_read;
    logic [7:0] csoc_data_i;
    logic       csoc_uart_write;
    logic       busy;
    logic       ovf;

    // master: the sequencer itself; slave: the UART pair plus CSoC around it
    modport master (
        input  rx_data, new_rx_data, tx_busy, csoc_data_i, csoc_uart_write,
        output tx_data, new_tx_data, csoc_clk, csoc_rstn, csoc_test_se,
        output csoc_test_tm, csoc_data_o, csoc_uart_read, busy, ovf
    );
    modport slave (
        output rx_data, new_rx_data, tx_busy, csoc_data_i, csoc_uart_write,
        input  tx_data, new_tx_data, csoc_clk, csoc_rstn, csoc_test_se,
        input  csoc_test_tm, csoc_data_o, csoc_uart_read, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/csoc_uart_seq.sv
`default_nettype none
// ============================================================================
// Module   : csoc_uart_seq
// Brief    : ASCII command sequencer driving CSoC reset/test/clock/data, with
//            UART transmit arbitration between responses and CSoC bytes.
// Revision : 1.0
// ============================================================================
module csoc_uart_seq #(
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned ARG_TIMEOUT = 1000000
) (
    input  logic            clk,
    input  logic            rstn,
    csoc_uart_seq_if.master bus
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_ARG = 3'd1;
    localparam logic [2:0] ST_RST_LO   = 3'd2;
    localparam logic [2:0] ST_CLK_HI   = 3'd3;
    localparam logic [2:0] ST_CLK_LO   = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_PULSE = 2'd1;
    localparam logic [1:0] TX_GUARD = 2'd2;
    localparam logic [1:0] TX_WAIT  = 2'd3;

    localparam logic [7:0] CH_ACK = 8'h4B;
    localparam logic [7:0] CH_ERR = 8'h3F;

    localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF_PERIOD - 1);
    localparam logic [31:0] ARG_LAST  = 32'(ARG_TIMEOUT - 1);

    logic [2:0]  state;
    logic [31:0] cnt;
    logic [8:0]  pulses;
    logic        arg_is_w;
    logic        read_pend;
    logic [7:0]  pend_byte;
    logic [7:0]  resp_byte;
    logic        resp_full;
    logic [7:0]  hold_byte;
    logic        hold_full;
    logic [1:0]  tx_state;
    logic        tx_sel;
    logic        resp_free;
    logic        hold_free;
    logic        resp_load;

    // A slot is released during the cycle its byte is on new_tx_data
    assign resp_free = (tx_state == TX_PULSE) && !tx_sel;
    assign hold_free = (tx_state == TX_PULSE) &&  tx_sel;
    assign resp_load = (state == ST_RESP) && (!resp_full || resp_free);
    assign bus.busy  = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= ST_IDLE;
            cnt                <= 32'd0;
            pulses             <= 9'd0;
            arg_is_w           <= 1'b0;
            read_pend          <= 1'b0;
            pend_byte          <= 8'd0;
            bus.csoc_clk       <= 1'b0;
            bus.csoc_rstn      <= 1'b0;
            bus.csoc_test_se   <= 1'b0;
            bus.csoc_test_tm   <= 1'b0;
            bus.csoc_data_o    <= 8'd0;
            bus.csoc_uart_read <= 1'b0;
        end else begin
            // read strobe trails the data update by one cycle
            read_pend          <= 1'b0;
            bus.csoc_uart_read <= read_pend;
            case (state)
                ST_IDLE: begin
                    if (bus.new_rx_data) begin
                        cnt <= 32'd0;
                        case (bus.rx_data)
                            8'h52: begin bus.csoc_rstn <= 1'b0; state <= ST_RST_LO; end
                            8'h53: begin bus.csoc_test_se <= 1'b1; pend_byte <= CH_ACK; state <= ST_RESP; end
                            8'h73: begin bus.csoc_test_se <= 1'b0; pend_byte <= CH_ACK; state <= ST_RESP; end
                            8'h54: begin bus.csoc_test_tm <= 1'b1; pend_byte <= CH_ACK; state <= ST_RESP; end
                            8'h74: begin bus.csoc_test_tm <= 1'b0; pend_byte <= CH_ACK; state <= ST_RESP; end
                            8'h43: begin arg_is_w <= 1'b0; state <= ST_WAIT_ARG; end
                            8'h57: begin arg_is_w <= 1'b1; state <= ST_WAIT_ARG; end
                            8'h47: begin pend_byte <= bus.csoc_data_i; state <= ST_RESP; end
                            default: begin pend_byte <= CH_ERR; state <= ST_RESP; end
                        endcase
                    end
                end
                ST_WAIT_ARG: begin
                    if (bus.new_rx_data) begin
                        cnt <= 32'd0;
                        if (arg_is_w) begin
                            bus.csoc_data_o <= bus.rx_data;
                            read_pend       <= 1'b1;
                            pend_byte       <= CH_ACK;
                            state           <= ST_RESP;
                        end else begin
                            pulses       <= {bus.rx_data == 8'd0, bus.rx_data};
                            bus.csoc_clk <= 1'b1;
                            state        <= ST_CLK_HI;
                        end
                    end else if (cnt == ARG_LAST) begin
                        pend_byte <= CH_ERR;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_RST_LO: begin
                    if (cnt == RST_LAST) begin
                        bus.csoc_rstn <= 1'b1;
                        pend_byte     <= CH_ACK;
                        state         <= ST_RESP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_CLK_HI: begin
                    if (cnt == HALF_LAST) begin
                        cnt          <= 32'd0;
                        bus.csoc_clk <= 1'b0;
                        state        <= ST_CLK_LO;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_CLK_LO: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= 32'd0;
                        if (pulses == 9'd1) begin
                            pend_byte <= CH_ACK;
                            state     <= ST_RESP;
                        end else begin
                            pulses       <= pulses - 9'd1;
                            bus.csoc_clk <= 1'b1;
                            state        <= ST_CLK_HI;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_load) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_byte <= 8'd0;
            resp_full <= 1'b0;
            hold_byte <= 8'd0;
            hold_full <= 1'b0;
            bus.ovf   <= 1'b0;
        end else begin
            if (resp_load) begin
                resp_byte <= pend_byte;
                resp_full <= 1'b1;
            end else if (resp_free) begin
                resp_full <= 1'b0;
            end
            if (bus.csoc_uart_write) begin
                if (!hold_full || hold_free) begin
                    hold_byte <= bus.csoc_data_i;
                    hold_full <= 1'b1;
                end else begin
                    bus.ovf <= 1'b1;
                end
            end else if (hold_free) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state        <= TX_IDLE;
            tx_sel          <= 1'b0;
            bus.tx_data     <= 8'd0;
            bus.new_tx_data <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!bus.tx_busy && (resp_full || hold_full)) begin
                        tx_sel          <= !resp_full;
                        bus.tx_data     <= resp_full ? resp_byte : hold_byte;
                        bus.new_tx_data <= 1'b1;
                        tx_state        <= TX_PULSE;
                    end
                end
                TX_PULSE: begin
                    bus.new_tx_data <= 1'b0;
                    tx_state        <= TX_GUARD;
                end
                TX_GUARD: tx_state <= TX_WAIT;
                TX_WAIT: begin
                    if (!bus.tx_busy) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
